repeater_traffic_gen: RTL and testbench
=======================================

# repeater_traffic_gen

Stimulus source for multichip repeater links. Drives a 64-bit val/rdy stream with a deterministic LFSR sequence into the repeater input and throttles the repeater output with a programmable rdy pattern. Counts flits in both directions and reports completion. Paired with the repeater checker on the same two links for on-chip link bring-up and soak tests.

## Interface
- SEED, 64'h0000_0000_0000_0001: LFSR value of the first flit; a value of 0 is replaced by 1.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse, begins a run; ignored unless state is IDLE or DONE
- num_flits  in  32  flits per run, sampled on start
- val_gap  in  4  idle cycles inserted after each accepted flit, sampled on start
- rdy_gap  in  4  low cycles between rdy_out pulses, sampled on start
- val_out  out  1  valid to repeater input
- dat_out  out  64  data to repeater input, equals the LFSR register
- rdy_in  in  1  ready from repeater input
- val_in  in  1  valid from repeater output
- rdy_out  out  1  ready to repeater output
- busy  out  1  state is SEND or DRAIN
- done  out  1  state is DONE
- sent_cnt  out  32  flits accepted on the TX side (val_out & rdy_in)
- recv_cnt  out  32  flits accepted on the RX side (val_in & rdy_out)
- overrun  out  1  sticky; set when an RX flit arrives while recv_cnt == num_flits

## Operation
- States: IDLE, SEND, DRAIN, DONE. Reset puts the block in IDLE.
- Reset values: val_out=0, rdy_out=0, busy=0, done=0, sent_cnt=0, recv_cnt=0, overrun=0, dat_out=SEED (or 1 if SEED is 0).
- IDLE/DONE + start:
  - Latch num_flits, val_gap and rdy_gap.
  - Clear sent_cnt, recv_cnt and overrun.
  - Load the LFSR with SEED.
  - Go to SEND, or directly to DONE if num_flits == 0.
- LFSR step on each TX acceptance: next = {lfsr[62:0], lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59]}.
- SEND, TX side:
  - val_out and dat_out stay stable until accepted.
  - After an acceptance, val_out is low for val_gap cycles, then high with the next LFSR value.
  - When the acceptance makes sent_cnt == num_flits, go to DRAIN; val_out is 0 from then on.
- SEND/DRAIN, RX side:
  - rdy_out is high for 1 cycle, then low for rdy_gap cycles, repeating.
  - With rdy_gap == 0, rdy_out is held high.
  - The pattern counter restarts on entry to SEND.
- DRAIN: when recv_cnt == num_flits, go to DONE. rdy_out stays active in DRAIN.
- DONE/IDLE: rdy_out = 0 and val_out = 0. done stays high until the next start.
- Counter width:
  - Counters are 32-bit and never wrap within a run (bounded by num_flits).
  - recv_cnt saturates at num_flits; extra RX acceptances set overrun instead of incrementing.
- start during SEND/DRAIN is ignored. Changes to num_flits or the gaps mid-run have no effect.
- rst_n low mid-run aborts the run immediately to reset values. No flit is completed.

## Timing
- All outputs are registered.
- start sampled at cycle 0 → busy=1, val_out=1, dat_out=SEED, rdy_out=1 at cycle 1.
- TX acceptance at cycle t:
  - With val_gap=0: next flit is valid at t+1.
  - With val_gap=g: val_out is low at t+1..t+g and high at t+g+1.
- Last TX acceptance at cycle t → state=DRAIN, val_out=0 at t+1.
- RX acceptance at cycle t that reaches num_flits → done=1, busy=0, rdy_out=0 at t+1.
- If the TX and RX final acceptances occur in the same cycle, go from SEND directly to DONE.
- A start in the same cycle as the DONE→IDLE condition is taken as a new run. Note: DONE persists until start, so there is no separate transition.

## Test plan
- SEED=1, num_flits=4, gaps=0, rdy_in=1, val_in looped from val_out:
  - dat_out = 1, 2, 4, 8 at cycles 1-4.
  - done=1 at cycle 5; sent_cnt=recv_cnt=4.
- val_gap=2, num_flits=3, rdy_in=1: val_out high at cycles 1, 4, 7 only; sent_cnt=3 at cycle 8.
- rdy_in low for cycles 1-5, then high: val_out=1 and dat_out=1 held constant through cycle 6; second flit (2) at cycle 7.
- rdy_gap=3: rdy_out high at cycles 1, 5, 9; val_in held at 1 → recv_cnt reaches 3 at cycle 10, done=1.
- num_flits=0 plus start → done=1 at cycle 1; val_out and rdy_out never assert.
- num_flits=2 with 3 RX flits injected: overrun=1 and recv_cnt=2. Separately, rst_n=0 mid-SEND → all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/repeater_traffic_gen.sv
// repeater_traffic_gen: LFSR val/rdy flit source plus throttled sink for
// repeater link bring-up and soak runs.
// Ports: clk, rst_n (sync, active-low); start, num_flits, val_gap, rdy_gap
//   configure and launch a run. TX: val_out/dat_out/rdy_in.
//   RX: val_in/rdy_out. Status: busy, done, sent_cnt, recv_cnt, overrun.
module repeater_traffic_gen #(
  parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] num_flits,
  input  logic [3:0]  val_gap,
  input  logic [3:0]  rdy_gap,
  output logic        val_out,
  output logic [63:0] dat_out,
  input  logic        rdy_in,
  input  logic        val_in,
  output logic        rdy_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] sent_cnt,
  output logic [31:0] recv_cnt,
  output logic        overrun
);

  localparam logic [63:0] SEED_NZ =
    (SEED == 64'd0) ? 64'd1 : SEED;

  typedef enum logic [1:0] {
    IDLE, SEND, DRAIN, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] lfsr_q;
  logic        val_q, rdy_q, ovr_q;
  logic [31:0] sent_q, recv_q, nf_q;
  logic [3:0]  vg_q, rg_q, vcnt_q, rcnt_q;

  logic tx_acc, rx_acc, tx_last;
  logic rx_full, rx_full_d;
  logic start_ok, active;

  assign tx_acc   = val_q & rdy_in;
  assign rx_acc   = val_in & rdy_q;
  assign tx_last  = tx_acc && (sent_q + 32'd1 == nf_q);
  assign rx_full  = (recv_q == nf_q);
  // RX count will equal num_flits after this edge
  assign rx_full_d = rx_full ||
    (rx_acc && (recv_q + 32'd1 == nf_q));
  assign start_ok = start &&
    (state_q == IDLE || state_q == DONE);
  assign active = (state_q == SEND) ||
    (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE:
        if (start)
          state_d = (num_flits == 32'd0) ? DONE : SEND;
      SEND:
        if (tx_last)
          state_d = rx_full_d ? DONE : DRAIN;
      DRAIN:
        if (rx_full_d) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED_NZ;
      val_q  <= 1'b0;
      rdy_q  <= 1'b0;
      ovr_q  <= 1'b0;
      sent_q <= '0;
      recv_q <= '0;
      nf_q   <= '0;
      vg_q   <= '0;
      rg_q   <= '0;
      vcnt_q <= '0;
      rcnt_q <= '0;
    end else if (start_ok) begin
      lfsr_q <= SEED_NZ;
      nf_q   <= num_flits;
      vg_q   <= val_gap;
      rg_q   <= rdy_gap;
      sent_q <= '0;
      recv_q <= '0;
      ovr_q  <= 1'b0;
      vcnt_q <= '0;
      rcnt_q <= '0;
      val_q  <= (num_flits != 32'd0);
      rdy_q  <= (num_flits != 32'd0);
    end else if (active) begin
      // TX: hold until accepted, then idle vg_q cycles
      if (tx_acc) begin
        lfsr_q <= {lfsr_q[62:0],
          lfsr_q[63] ^ lfsr_q[62] ^
          lfsr_q[60] ^ lfsr_q[59]};
        sent_q <= sent_q + 32'd1;
        val_q  <= !tx_last && (vg_q == 4'd0);
        vcnt_q <= vg_q;
      end else if (!val_q && state_q == SEND &&
                   vcnt_q != 4'd0) begin
        vcnt_q <= vcnt_q - 4'd1;
        if (vcnt_q == 4'd1) val_q <= 1'b1;
      end
      // RX: saturate at num_flits, flag extras
      if (rx_acc) begin
        if (rx_full) ovr_q  <= 1'b1;
        else         recv_q <= recv_q + 32'd1;
      end
      // rdy pattern: one high, rg_q low, repeat
      if (state_d == DONE) begin
        rdy_q <= 1'b0;
        val_q <= 1'b0;
      end else if (rdy_q) begin
        if (rg_q != 4'd0) begin
          rdy_q  <= 1'b0;
          rcnt_q <= rg_q;
        end
      end else begin
        rcnt_q <= rcnt_q - 4'd1;
        if (rcnt_q <= 4'd1) rdy_q <= 1'b1;
      end
    end
  end

  assign val_out  = val_q;
  assign dat_out  = lfsr_q;
  assign rdy_out  = rdy_q;
  assign busy     = active;
  assign done     = (state_q == DONE);
  assign sent_cnt = sent_q;
  assign recv_cnt = recv_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_repeater_traffic_gen.sv
// tb_repeater_traffic_gen: directed and randomized checks of
// repeater_traffic_gen against a rule-level reference model.
module tb_repeater_traffic_gen;

  localparam logic [63:0] SEED = 64'h1;

  logic        clk = 1'b0;
  logic        rst_n, start, rdy_in;
  logic        val_in, val_in_drv, loop_en;
  logic [31:0] num_flits;
  logic [3:0]  val_gap, rdy_gap;
  logic        val_out, rdy_out, busy, done, overrun;
  logic [63:0] dat_out;
  logic [31:0] sent_cnt, recv_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign val_in = loop_en ? val_out : val_in_drv;

  repeater_traffic_gen #(.SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_flits(num_flits), .val_gap(val_gap),
    .rdy_gap(rdy_gap), .val_out(val_out),
    .dat_out(dat_out), .rdy_in(rdy_in),
    .val_in(val_in), .rdy_out(rdy_out),
    .busy(busy), .done(done),
    .sent_cnt(sent_cnt), .recv_cnt(recv_cnt),
    .overrun(overrun)
  );

  function automatic logic [63:0] lfsr_next(
    input logic [63:0] v);
    return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] nf,
                          input logic [3:0] vg,
                          input logic [3:0] rg);
    num_flits = nf;
    val_gap   = vg;
    rdy_gap   = rg;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    num_flits = $urandom;
    val_gap   = 4'($urandom);
    rdy_gap   = 4'($urandom);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_val"}, val_out, 0);
    chk({tag, "_rdy"}, rdy_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sent"}, sent_cnt, 0);
    chk({tag, "_recv"}, recv_cnt, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_dat"}, dat_out, SEED);
  endtask

  initial begin
    logic [63:0] m_lfsr;
    int nf, vg, rg, m_sent, m_recv, gap_left;
    bit m_ovr, tx_done, fin, e_val, e_rdy;
    bit r_rdy, r_val;

    rst_n = 1'b0; start = 1'b0; rdy_in = 1'b0;
    val_in_drv = 1'b0; loop_en = 1'b0;
    num_flits = '0; val_gap = '0; rdy_gap = '0;
    tick(); tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // T1: loopback, no gaps
    rdy_in = 1'b1; loop_en = 1'b1;
    do_start(4, 0, 0);
    chk("t1_busy", busy, 1);
    chk("t1_rdy", rdy_out, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_dat%0d", i), dat_out,
          64'd1 << i);
      chk($sformatf("t1_val%0d", i), val_out, 1);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_sent", sent_cnt, 4);
    chk("t1_recv", recv_cnt, 4);

    // T2: val_gap=2, valid at cycles 1,4,7
    do_start(3, 2, 0);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t2_val_c%0d", c), val_out,
          (c == 1 || c == 4 || c == 7));
      if (c == 8) chk("t2_sent", sent_cnt, 3);
      if (c < 8) tick();
    end

    // T3: rdy_in low cycles 1-5
    rdy_in = 1'b0;
    do_start(2, 0, 0);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 6) begin
        chk($sformatf("t3_val_c%0d", c), val_out, 1);
        chk($sformatf("t3_dat_c%0d", c), dat_out, 1);
      end else begin
        chk("t3_dat2", dat_out, 2);
        chk("t3_val2", val_out, 1);
      end
      rdy_in = (c >= 6);
      tick();
    end
    chk("t3_done", done, 1);

    // T4: rdy_gap=3, val_in held high
    loop_en = 1'b0; val_in_drv = 1'b1; rdy_in = 1'b1;
    do_start(3, 0, 3);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("t4_rdy_c%0d", c), rdy_out,
          (c == 1 || c == 5 || c == 9));
      if (c == 9) chk("t4_recv9", recv_cnt, 2);
      if (c < 10) tick();
    end
    chk("t4_recv", recv_cnt, 3);
    chk("t4_done", done, 1);

    // T5: zero-flit run
    do_start(0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("t5_done_c%0d", c), done, 1);
      chk($sformatf("t5_val_c%0d", c), val_out, 0);
      chk($sformatf("t5_rdy_c%0d", c), rdy_out, 0);
      tick();
    end

    // Randomized runs vs rule-level model
    for (int run = 0; run < 30; run++) begin
      nf = $urandom_range(1, 12);
      vg = $urandom_range(0, 5);
      rg = $urandom_range(0, 5);
      rdy_in = 1'b0; val_in_drv = 1'b0;
      do_start(nf, 4'(vg), 4'(rg));
      m_lfsr = SEED; m_sent = 0; m_recv = 0;
      m_ovr = 0; tx_done = 0; fin = 0; gap_left = 0;
      for (int c = 1; c <= 400 && !fin; c++) begin
        chk("r_busy", busy, 1);
        chk("r_done", done, 0);
        e_val = !tx_done && gap_left == 0;
        e_rdy = (rg == 0) || ((c - 1) % (rg + 1) == 0);
        chk($sformatf("r%0d_val_c%0d", run, c),
            val_out, e_val);
        if (e_val)
          chk($sformatf("r%0d_dat_c%0d", run, c),
              dat_out, m_lfsr);
        chk($sformatf("r%0d_rdy_c%0d", run, c),
            rdy_out, e_rdy);
        chk("r_sent", sent_cnt, m_sent);
        chk("r_recv", recv_cnt, m_recv);
        chk("r_ovr", overrun, m_ovr);
        r_rdy = ($urandom_range(0, 99) < 60);
        r_val = ($urandom_range(0, 99) < 70);
        rdy_in = r_rdy; val_in_drv = r_val;
        start = (c == 3);
        num_flits = $urandom_range(0, 20);
        if (e_val && r_rdy) begin
          m_lfsr = lfsr_next(m_lfsr);
          m_sent++;
          gap_left = vg;
          if (m_sent == nf) tx_done = 1;
        end else if (gap_left > 0) begin
          gap_left--;
        end
        if (e_rdy && r_val) begin
          if (m_recv == nf) m_ovr = 1;
          else m_recv++;
        end
        if (tx_done && m_recv == nf) fin = 1;
        tick();
        start = 1'b0;
      end
      chk("r_timeout", fin, 1);
      chk("r_fin_done", done, 1);
      chk("r_fin_busy", busy, 0);
      chk("r_fin_val", val_out, 0);
      chk("r_fin_rdy", rdy_out, 0);
      chk("r_fin_sent", sent_cnt, nf);
      chk("r_fin_recv", recv_cnt, nf);
      chk("r_fin_ovr", overrun, m_ovr);
    end

    // T6: overrun, then reset mid-SEND
    rdy_in = 1'b0; val_in_drv = 1'b1;
    do_start(2, 0, 0);
    tick(); tick(); tick();
    chk("t6_recv", recv_cnt, 2);
    chk("t6_ovr", overrun, 1);
    chk("t6_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("t6_rst");
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
